dmem_banked: RTL
================

Name: dmem_banked

Overview:
- Parametrised successor to the fixed four-bank data memory.
- Generalised in bank count, bank depth and data width.
- Adds a valid/ready request/response handshake, byte/half/word accesses using big-endian lanes and per-byte write masks, and error reporting for misaligned or out-of-range accesses.
- Sits between the core load/store unit and NBANK la_spram instances.

Parameters:
- DW, 32, data width in bits; legal values are 32 and 64.
- AW, 8, word-address bits per bank; each bank holds 2^AW words.
- NBANK, 4, number of banks; must be a power of 2 and at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DW=64).
- req_unsigned  in  1  zero-extend the load result (used only with the optional feature).
- req_addr  in  32  byte address.
- req_wdata  in  DW  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DW  load data, right-justified; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, on port reset.
- Address decode:
  - LB = log2(DW/8) = byte offset bits.
  - Word index = addr[AW+LB-1:LB].
  - Bank = addr[AW+LB+BB-1:AW+LB], where BB = log2(NBANK); bank is 0 when NBANK=1.
  - Any addr bit above AW+LB+BB set means out of range.
- Lane order is big-endian: byte offset 0 maps to bits [DW-1:DW-8].
- Stores: data is shifted into the addressed lanes and wmask enables only those bytes.
- Error conditions:
  - Misaligned: addr is not a multiple of 2^size.
  - Illegal size: size=11 with DW=32.
  - Out of range, as defined above.
  - On error no bank is enabled; the response carries rsp_err=1 and rsp_rdata=0.
- States: IDLE, RESP, HOLD.
  - IDLE: req_ready=1, rsp_valid=0.
  - Accept (req_valid & req_ready) in cycle T: only the addressed bank gets ce=1, with we=req_we; next state is RESP.
  - RESP: rsp_valid=1. For a load, rsp_rdata is the lane-extracted bank dout (SRAM read latency 1).
  - RESP & rsp_ready: return to IDLE, or stay in RESP if a new request is accepted in the same cycle.
  - RESP & !rsp_ready: capture the formatted data and err into the hold register; next state is HOLD.
  - HOLD: outputs come from the hold register and stay stable. On rsp_ready, behave as in RESP with rsp_ready.
- Handshake and throughput:
  - req_ready = (state==IDLE) | rsp_ready.
  - Sustained throughput is 1 request/cycle.
  - Fixed load-to-response latency is 1 cycle.
- Response ordering: responses return in order; at most one is outstanding.
- Stores: a response with rdata=0 is returned one cycle after accept.
- Load results: without the optional feature, the extracted byte/half is zero-extended.
- Reset:
  - state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, hold register=0.
  - An in-flight response is dropped.
  - A store enabled in the reset cycle is suppressed (ce gated by !reset).
  - Memory contents are not reset.
- Simultaneous events: a load from an address stored in the previous cycle returns the new data, because SRAM write precedes the next read.

Optional Feature:
- Macro: DMEM_BANKED_SIGNEXT_EN.
- Defined: loads narrower than DW are sign-extended when req_unsigned=0 and zero-extended when req_unsigned=1. req_unsigned is registered at accept.
- Undefined: req_unsigned is ignored; all narrow loads are zero-extended.

Decomposition:
- Package dmem_banked_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the state enum IDLE/RESP/HOLD;
  - functions for lane mask and legal-alignment.
- Sub-module dmem_lane_align (combinational): store shift plus wmask generation, and load extract plus extension. It is instantiated once for the write path and once for the read path.
- Top level holds the decode, FSM, hold register and the generate loop of la_spram.

Test Plan:
- DW=32, NBANK=4: store word 0xDEADBEEF at 0x104, then load word 0x104 → rsp_rdata=0xDEADBEEF, err=0, one cycle after accept.
- Store byte 0xA5 at 0x101, then load byte 0x101 → 0x000000A5; load word 0x100 → byte 1 (bits[23:16]) = 0xA5, other bytes unchanged.
- Load half at 0x103 → rsp_err=1, rdata=0, no SRAM ce. Load word at 0x1000 (out of range for AW=8, NBANK=4) → rsp_err=1.
- Back-to-back: 4 loads with rsp_ready held at 1 → 4 responses on consecutive cycles, req_ready stays 1. Drop rsp_ready for 3 cycles mid-burst → rsp_rdata held stable, req_ready=0, no loss.
- With DMEM_BANKED_SIGNEXT_EN: 0x80 stored at 0x10, load byte with req_unsigned=0 → 0xFFFFFF80; with req_unsigned=1 → 0x00000080.
- Assert reset in RESP with rsp_ready=0 → next cycle rsp_valid=0, req_ready=1; a store issued in the reset cycle does not modify memory.

Source files
------------

// File: rtl/dmem_banked_pkg.sv
// Shared encodings, FSM state type and lane/alignment helpers for dmem_banked.
package dmem_banked_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Byte enables: bit j covers data bits [8j+7:8j]; lane 0 is the most significant byte.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] offset,
                                             input int         nbytes);
        logic [7:0] m;
        int         n;
        int         lane;
        m = '0;
        n = 1 << size;
        for (int j = 0; j < 8; j++) begin
            lane = nbytes - 1 - j;
            if (j < nbytes && lane >= int'(offset) && lane < int'(offset) + n)
                m[j] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [2:0] addr_lsb);
        logic [2:0] low;
        low = 3'((1 << size) - 1);
        return (addr_lsb & low) == 3'd0;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: STORE=1 shifts store data into lanes and builds the
// byte mask; STORE=0 extracts the addressed lanes and extends them.
module dmem_lane_align
    import dmem_banked_pkg::*;
#(
    parameter int DW    = 32,
    parameter bit STORE = 1'b1
) (
    input  logic [1:0]               size_i,
    input  logic [$clog2(DW/8)-1:0]  offset_i,
    input  logic                     sext_i,
    input  logic [DW-1:0]            data_i,
    output logic [DW-1:0]            data_o,
    output logic [DW/8-1:0]          mask_o
);

    localparam int NB = DW / 8;

    int            nbytes_acc;
    int            shamt;
    int            msb;
    logic [DW-1:0] shifted;

    always_comb begin
        mask_o     = NB'(lane_mask(size_i, 3'(offset_i), NB));
        nbytes_acc = 1 << size_i;
        // distance from the right-justified position to the addressed lanes
        shamt      = DW - 8 * (int'(offset_i) + nbytes_acc);
        if (shamt < 0)
            shamt = 0;
        msb        = (8 * nbytes_acc > DW) ? DW - 1 : 8 * nbytes_acc - 1;
        shifted    = STORE ? (data_i << shamt) : (data_i >> shamt);
        data_o     = shifted;
        if (!STORE) begin
            for (int b = 0; b < DW; b++) begin
                if (b > msb)
                    data_o[b] = sext_i & shifted[msb];
            end
        end
    end

endmodule

// File: rtl/la_spram.sv
// Single-port SRAM model with per-bit write mask and one-cycle read latency.
module la_spram #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [DW-1:0] wmask,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (ce && we)
            mem_q[addr] <= (mem_q[addr] & ~wmask) | (din & wmask);
        if (ce && !we)
            dout <= mem_q[addr];
    end

endmodule

// File: rtl/dmem_banked.sv
// Banked data memory with valid/ready handshake, sub-word big-endian access and
// error reporting. Define DMEM_BANKED_SIGNEXT_EN to sign-extend narrow loads.
module dmem_banked
    import dmem_banked_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int NBANK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int BB = (NBANK > 1) ? $clog2(NBANK) : 0;
    localparam int BW = (BB > 0) ? BB : 1;

    state_e        state_q, state_d;
    logic          ld_q, ld_d;
    logic          err_q, err_d;
    logic [BW-1:0] bank_q, bank_d;
    logic [1:0]    size_q, size_d;
    logic [LB-1:0] off_q, off_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          hold_err_q, hold_err_d;

    logic          accept;
    logic [AW-1:0] word_idx;
    logic [BW-1:0] bank_idx;
    logic [LB-1:0] byte_off;
    logic          oor, misal, bad_size, req_err;

    assign byte_off = req_addr[LB-1:0];
    assign word_idx = req_addr[AW+LB-1:LB];
    assign bank_idx = BW'((req_addr >> (AW + LB)) & 32'(NBANK - 1));
    assign oor      = (req_addr >> (AW + LB + BB)) != 32'd0;
    assign misal    = !is_aligned(req_size, req_addr[2:0]);
    assign bad_size = (req_size == SZ_D) && (DW == 32);
    assign req_err  = oor | misal | bad_size;

    assign req_ready = (state_q == IDLE) | rsp_ready;
    assign accept    = req_valid & req_ready;

    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_bmask;
    logic [DW-1:0] wr_wmask;

    dmem_lane_align #(.DW(DW), .STORE(1'b1)) u_wr_align (
        .size_i   (req_size),
        .offset_i (byte_off),
        .sext_i   (1'b0),
        .data_i   (req_wdata),
        .data_o   (wr_data),
        .mask_o   (wr_bmask)
    );

    always_comb begin
        wr_wmask = '0;
        for (int i = 0; i < DW; i++)
            wr_wmask[i] = wr_bmask[i/8];
    end

    logic [DW-1:0] bank_dout [NBANK];

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        logic ce;
        // reset suppresses any access presented in the same cycle
        assign ce = accept & ~req_err & ~reset & (bank_idx == BW'(g));
        la_spram #(.DW(DW), .AW(AW)) u_ram (
            .clk   (clk),
            .ce    (ce),
            .we    (req_we),
            .wmask (wr_wmask),
            .addr  (word_idx),
            .din   (wr_data),
            .dout  (bank_dout[g])
        );
    end

    logic          rd_sext;
    logic [DW-1:0] rd_data;
    logic [NB-1:0] rd_mask_unused;
    logic [DW-1:0] fmt_data;

`ifdef DMEM_BANKED_SIGNEXT_EN
    logic uns_q, uns_d;
    assign uns_d   = accept ? req_unsigned : uns_q;
    assign rd_sext = ~uns_q;
    always_ff @(posedge clk) begin
        if (reset)
            uns_q <= 1'b0;
        else
            uns_q <= uns_d;
    end
`else
    logic req_unsigned_unused;
    assign req_unsigned_unused = req_unsigned;
    assign rd_sext             = 1'b0;
`endif

    dmem_lane_align #(.DW(DW), .STORE(1'b0)) u_rd_align (
        .size_i   (size_q),
        .offset_i (off_q),
        .sext_i   (rd_sext),
        .data_i   (bank_dout[bank_q]),
        .data_o   (rd_data),
        .mask_o   (rd_mask_unused)
    );

    assign fmt_data = ld_q ? rd_data : '0;

    assign ld_d   = accept ? (~req_we & ~req_err) : ld_q;
    assign err_d  = accept ? req_err : err_q;
    assign bank_d = accept ? bank_idx : bank_q;
    assign size_d = accept ? req_size : size_q;
    assign off_d  = accept ? byte_off : off_q;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_err_d  = hold_err_q;
        case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP: begin
                if (rsp_ready)
                    state_d = accept ? RESP : IDLE;
                else begin
                    state_d     = HOLD;
                    hold_data_d = fmt_data;
                    hold_err_d  = err_q;
                end
            end
            HOLD: if (rsp_ready) state_d = accept ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q != IDLE);
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (state_q == RESP) begin
            rsp_rdata = fmt_data;
            rsp_err   = err_q;
        end else if (state_q == HOLD) begin
            rsp_rdata = hold_data_q;
            rsp_err   = hold_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ld_q        <= 1'b0;
            err_q       <= 1'b0;
            bank_q      <= '0;
            size_q      <= SZ_B;
            off_q       <= '0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            err_q       <= err_d;
            bank_q      <= bank_d;
            size_q      <= size_d;
            off_q       <= off_d;
            hold_data_q <= hold_data_d;
            hold_err_q  <= hold_err_d;
        end
    end

endmodule
